// File: rtl/divide_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divide_unit_pkg
//  Description : Shared op/state encodings and op-decoding helpers for the
//                iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package divide_unit_pkg;

    typedef logic [1:0] div_op_t;
    typedef logic [1:0] div_state_t;

    localparam div_op_t DIV_OP_DIV  = 2'b00;
    localparam div_op_t DIV_OP_DIVU = 2'b01;
    localparam div_op_t DIV_OP_REM  = 2'b10;
    localparam div_op_t DIV_OP_REMU = 2'b11;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_DONE = 2'd2;

    function automatic logic div_is_signed(input div_op_t op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(input div_op_t op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divide_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : divide_unit_if
//  Description : Request/response bundle between execute stage and divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divide_unit_if #(
    parameter int WIDTH = 32
);
    import divide_unit_pkg::*;

    logic             start;
    div_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);

endinterface
`default_nettype wire

// File: rtl/divider_step.sv
`default_nettype none
// ============================================================================
//  Module      : divider_step
//  Description : One combinational restoring-division step on {rem, quo}.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic [WIDTH-1:0] i_quo,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic      [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // rem < divisor on entry, so the difference always fits a signed WIDTH+1 word
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_diff[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b1};
        if (w_diff[WIDTH]) begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/divide_unit.sv
`default_nettype none
// ============================================================================
//  Module      : divide_unit
//  Description : Iterative signed/unsigned divider (DIV/DIVU/REM/REMU), one
//                restoring step per clock, one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module divide_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    divide_unit_if.slave bus
);
    import divide_unit_pkg::*;

    localparam int              c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_min  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t         r_state;
    div_state_t         w_state_nx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic               w_last;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_calc_res;

    assign w_accept   = bus.start && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
    assign w_signed   = div_is_signed(bus.op);
    assign w_a_neg    = w_signed & bus.a[WIDTH-1];
    assign w_b_neg    = w_signed & bus.b[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -bus.a : bus.a;
    assign w_b_abs    = w_b_neg ? -bus.b : bus.b;
    assign w_div_zero = (bus.b == '0);
    assign w_ovf      = w_signed && (bus.a == c_min) && (bus.b == '1);
    assign w_special  = w_div_zero | w_ovf;

    // Divide-by-zero wins; on signed overflow the dividend is the quotient
    always_comb begin
        w_special_res = div_is_rem(bus.op) ? '0 : bus.a;
        if (w_div_zero) begin
            w_special_res = div_is_rem(bus.op) ? bus.a : '1;
        end
    end

    divider_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    assign w_last     = (r_cnt == c_last);
    assign w_calc_res = r_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                                 : (r_neg_q ? -w_quo_nx : w_quo_nx);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            DIV_IDLE, DIV_DONE: begin
                if (w_accept) begin
                    w_state_nx = w_special ? DIV_DONE : DIV_CALC;
                end else begin
                    w_state_nx = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                if (w_last) begin
                    w_state_nx = DIV_DONE;
                end
            end
            default: w_state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_is_rem <= div_is_rem(bus.op);
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_div    <= w_b_abs;
                r_quo    <= w_a_abs;
                r_rem    <= '0;
                r_cnt    <= '0;
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end else if (r_state == DIV_CALC) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_calc_res;
                end
            end
        end
    end

    assign bus.busy   = (r_state == DIV_CALC);
    assign bus.done   = (r_state == DIV_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_divide_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divide_unit
//  Description : Directed vector bench for divide_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divide_unit;
    import divide_unit_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    divide_unit_if #(.WIDTH(32)) bus ();

    divide_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is held across exactly one rising edge
    task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy, output logic overlap);
        cyc     = 0;
        nbusy   = 0;
        overlap = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.done) break;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   nbusy;
        logic ovl;
        string tag;
        @(negedge clk);
        apply(v.op, v.a, v.b);
        wait_done(cyc, nbusy, ovl);
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "_result"},    bus.result, v.exp);
        chk({tag, "_latency"},   32'(cyc - 1), 32'(v.lat));
        chk({tag, "_busy_cyc"},  32'(nbusy), 32'(v.lat));
        chk({tag, "_overlap"},   32'(ovl), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_held"},       bus.result, v.exp);
    endtask

    initial begin
        int   cyc;
        int   nbusy;
        int   ndone;
        logic ovl;
        vec_t v;

        n_checks  = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = DIV_OP_DIV;
        bus.a     = '0;
        bus.b     = '0;

        vecs.push_back('{DIV_OP_DIV,  32'd100,        32'd7,          32'd14,         32});
        vecs.push_back('{DIV_OP_REM,  32'd100,        32'd7,          32'd2,          32});
        vecs.push_back('{DIV_OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32});
        vecs.push_back('{DIV_OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   32});
        vecs.push_back('{DIV_OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          32});
        vecs.push_back('{DIV_OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32});
        vecs.push_back('{DIV_OP_DIVU, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32});
        vecs.push_back('{DIV_OP_REMU, 32'hFFFFFFFF,   32'd2,          32'd1,          32});
        vecs.push_back('{DIV_OP_DIV,  32'hFFFFFFFF,   32'd2,          32'd0,          32});
        vecs.push_back('{DIV_OP_DIVU, 32'h12345678,   32'h00001000,   32'h00012345,   32});
        vecs.push_back('{DIV_OP_REMU, 32'h12345678,   32'h00001000,   32'h00000678,   32});
        vecs.push_back('{DIV_OP_DIV,  32'h80000000,   32'd1,          32'h80000000,   32});
        vecs.push_back('{DIV_OP_DIV,  32'h80000000,   32'd3,          32'hD5555556,   32});
        vecs.push_back('{DIV_OP_REM,  32'h80000000,   32'd3,          32'hFFFFFFFE,   32});
        vecs.push_back('{DIV_OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32});
        vecs.push_back('{DIV_OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32});
        vecs.push_back('{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{DIV_OP_REMU, 32'd5,          32'd0,          32'd5,          0});
        vecs.push_back('{DIV_OP_REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   0});
        vecs.push_back('{DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0});
        vecs.push_back('{DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          0});

        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Start pulsed mid-calculation must be ignored
        @(negedge clk);
        apply(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        apply(DIV_OP_DIVU, 32'd1000, 32'd10);
        wait_done(cyc, nbusy, ovl);
        chk("midcalc_done",    32'(bus.done), 32'd1);
        chk("midcalc_result",  bus.result, 32'd14);
        chk("midcalc_latency", 32'(cyc), 32'd29);
        @(negedge clk);

        // Back-to-back: new op accepted in the DONE cycle
        apply(DIV_OP_DIV, 32'd100, 32'd7);
        wait_done(cyc, nbusy, ovl);
        chk("b2b_first", bus.result, 32'd14);
        apply(DIV_OP_REM, 32'd100, 32'd7);
        @(negedge clk);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done", 32'(bus.done), 32'd0);
        wait_done(cyc, nbusy, ovl);
        chk("b2b_done_seen", 32'(bus.done), 32'd1);
        chk("b2b_result",    bus.result, 32'd2);
        chk("b2b_latency",   32'(cyc), 32'd32);
        @(negedge clk);

        // Asynchronous reset in the middle of a calculation
        apply(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_busy",   32'(bus.busy), 32'd0);
        chk("abort_done",   32'(bus.done), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        v = '{DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 32};
        run_vec(99, v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/divide_unit.md
Name: divide_unit

Overview:
Iterative 32-bit integer divider that supplies the RV32M DIV/DIVU/REM/REMU operations beside the single-cycle arithmetic unit. It takes operands and a 2-bit op from the execute stage on a start pulse and runs one restoring-division step per clock. It returns a quotient or remainder with a one-cycle done pulse. The result is held for the control FSM until the next operation is accepted.

Parameters:
WIDTH, 32, operand and result width; iteration count equals WIDTH; counter is $clog2(WIDTH) bits.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready (state IDLE or DONE)
op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
a  input  WIDTH  dividend, sampled with start
b  input  WIDTH  divisor, sampled with start
busy  output  1  high while state CALC
done  output  1  one-cycle pulse, high while state DONE
result  output  WIDTH  registered result; valid from done, held until next accepted start

Behaviour:
- Reset (async, rstn=0): state=IDLE, busy=0, done=0, result=0, internal quotient, remainder and counter all cleared. Reset during CALC aborts the operation and produces no done pulse.
- States: IDLE, CALC, DONE. Start is accepted in IDLE or DONE; in CALC, start is ignored and a, b, op are not sampled.
- Accept edge (start=1 in IDLE/DONE): latch op, the operand signs, and |a| and |b|. Abs is applied for DIV/REM only; DIVU/REMU use raw values. Then clear the counter and the partial remainder and load the dividend shift register.
- Special cases, decided at the accept edge without iterating; the next state is DONE, so done is high in the cycle right after the start cycle:
  - b==0: DIV/DIVU result=all ones; REM/REMU result=a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF: result=0x80000000.
  - REM with the same operands: result=0.
- CALC: each edge performs one restoring step.
  - Shift the {rem, quo} pair left 1.
  - Trial subtract: rem - divisor, computed WIDTH+1 bits wide.
  - If non-negative, keep the difference and set quo LSB=1; else restore and set quo LSB=0.
  - Counter increments each edge.
- CALC exit: on the edge with counter==WIDTH-1, move to DONE and write result:
  - DIV: quotient, negated if sign(a) xor sign(b).
  - REM: remainder, negated if sign(a) (the remainder takes the dividend's sign).
  - DIVU/REMU: unsigned quotient/remainder.
- Latency, normal path: start sampled at edge 0; CALC occupies edges 1..WIDTH; done is high in the cycle after edge WIDTH (32 cycles after the start edge).
- DONE lasts exactly one cycle. Without start, the next state is IDLE; with start, the unit accepts back-to-back. result is unchanged in IDLE.
- busy=1 exactly for the WIDTH cycles in CALC; busy and done are never high together.
- All arithmetic is modulo 2^WIDTH; negation is two's complement. No X propagation from unsampled inputs.

Decomposition:
- Shared package (alongside the ALU op constants):
  - op encodings DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11.
  - State encoding localparams DIV_IDLE, DIV_CALC, DIV_DONE.
- Sub-module divider_step: combinational single restoring step. Inputs: rem, quo, divisor. Outputs: next rem and next quo. It is instantiated once and unit-tested separately.
- The top level holds the FSM, counter, sign/abs handling, special cases and the result register.

Test Plan:
- DIV a=100, b=7, start one cycle -> busy high 32 cycles, done after 32 cycles, result=14; REM same operands -> 2.
- DIV a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2); REM a=100, b=-7 -> 2.
- DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; REMU -> 1; DIV same operands -> 0 (signed -1/2).
- Divide by zero: DIV a=5, b=0 -> done in the cycle after start, result=0xFFFFFFFF; REMU a=5, b=0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start pulsed mid-CALC with different operands -> ignored, original result delivered. Start during the DONE cycle -> new op accepted, busy the next cycle.
- rstn low at CALC cycle 10 -> busy=0, done=0, result=0 immediately; no done pulse afterward; a fresh start after release gives the correct result.
